fp_addsub_special_pipe: RTL
===========================

Name: fp_addsub_special_pipe

Overview:
- Parametrised special-operand handler for the pipelined floating-point add/sub datapath.
- Classifies both operands (NaN, Inf, zero, denormal, normal) and detects exact cancellation.
- Produces the IEEE-754 special result and flags, delayed by LATENCY stages so it lines up with the main adder pipeline.
- The top-level output mux selects this result when `special`=1. The main adder result is used otherwise.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored mantissa width (no hidden bit).
- LATENCY, 4, pipeline depth in cycles. Must be ≥1 and must equal the main adder latency.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- enable  in  1  pipeline advance; 0 freezes every stage
- in_valid  in  1  operands valid this cycle
- Sx, Ex, Mx  in  1/EXP_W/MAN_W  operand X
- Sy, Ey, My  in  1/EXP_W/MAN_W  operand Y
- sub  in  1  1 = X−Y, 0 = X+Y
- roundMode  in  2  00 RNE, 01 RZ, 10 RU (+inf), 11 RD (−inf)
- out_valid  out  1  result valid
- special  out  1  result below overrides the adder
- Sz, Ez, Mz  out  1/EXP_W/MAN_W  special result
- invalid_flag, zero_flag  out  1  IEEE flags (overflow/inexact are never raised by this block)

Behaviour:
- Reset: all stage registers and all outputs go to 0, including out_valid and special. Reset has priority over enable.
- Effective Y sign: Sy_eff = Sy ^ sub.
- Operand classes:
  - NaN: E all-ones, M≠0.
  - sNaN: NaN with M[MAN_W-1]=0.
  - Inf: E all-ones, M=0.
  - Zero: E=0, M=0.
  - Otherwise finite nonzero.
- Canonical qNaN: S=0, E all-ones, M=1<<(MAN_W-1).
- Rules are evaluated in priority order:
  1. Either operand NaN → qNaN, special=1, invalid=1 iff either operand is sNaN.
  2. Both Inf and Sx≠Sy_eff → qNaN, invalid=1.
  3. Any Inf → Inf, sign of the Inf operand (Sx if X is Inf).
  4. Both zero → zero, zero_flag=1. Sign is Sx&Sy_eff, except RD where it is Sx|Sy_eff.
  5. Exactly one zero → pass the other operand unchanged (Y passed with Sy_eff), special=1, no flags.
  6. Finite nonzero, Ex==Ey, Mx==My, Sx≠Sy_eff → exact zero, zero_flag=1. Sign is 0, or 1 in RD.
  7. Otherwise special=0 and Sz/Ez/Mz/flags = 0.
- Pipeline:
  - Classification is combinational and captured in stage 1. Stages 2..LATENCY are plain delay.
  - Latency is exactly LATENCY enabled cycles from in_valid to out_valid.
  - When enable=1, each stage loads the previous one. A stage loaded with invalid data has every field cleared to 0.
  - When enable=0, all stages and outputs hold their values; in_valid is ignored that cycle.
  - Back-to-back issue at full rate is supported; there is no backpressure beyond enable.
- Reset mid-flight: all in-flight results are discarded. out_valid is 0 from the cycle after reset is asserted until new data reaches the last stage.

Optional Feature:
- Macro FP_SPECIAL_FTZ_EN.
- Defined: denormal inputs (E=0, M≠0) are treated as zero of the same sign for rules 4–6. A rule-5 pass-through of a denormal outputs a signed zero (M=0).
- Undefined: denormals are finite nonzero and are passed through unmodified.

Decomposition:
- Package fp_pkg holds:
  - default EXP_W/MAN_W;
  - roundMode encodings (RM_RNE, RM_RZ, RM_RU, RM_RD);
  - operand class enum (CLS_ZERO, CLS_DENORM, CLS_NORM, CLS_INF, CLS_QNAN, CLS_SNAN);
  - qNaN constant function.
- Sub-module fp_classify: a combinational single-operand classifier, instantiated twice. The top holds the rule logic and the pipeline.

Test Plan (defaults, LATENCY=4, enable=1 unless noted):
- Exact cancellation: Ex=Ey=8'hF0, Mx=My=23'h700000, Sx=Sy=0, sub=1, RNE → after 4 cycles out_valid=1, special=1, S=0, E=0, M=0, zero_flag=1. Same operands with RD → S=1.
- Inf − Inf: Ex=Ey=8'hFF, Mx=My=0, Sx=Sy=0, sub=1 → {S,E,M}=32'h7FC00000, invalid=1. Same with sub=0 → +Inf (32'h7F800000), invalid=0.
- NaN inputs:
  - X sNaN (E=FF, M=23'h000001) plus 1.0 → 32'h7FC00000, invalid=1.
  - X qNaN (M=23'h400000) plus 1.0 → same value, invalid=0.
- Signed zeros: +0 + −0, sub=0 → RNE gives +0, RD gives −0, zero_flag=1. Zero − 1.0 → −1.0 (32'hBF800000), zero_flag=0.
- Normal operands: 1.0 + 2.0 → special=0, flags 0, out_valid=1 after 4 cycles.
- Stall and reset: issue 3 consecutive operations, then hold enable=0 for 2 cycles starting at cycle 2.
  - Outputs freeze during the stall; results emerge at cycles 6, 7, 8 in order.
  - Repeat the sequence with rst=1 at cycle 2 → out_valid=0 through cycle 8.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants, operand classes and canonical-NaN helper for the FP add/sub datapath.
package fp_pkg;

    localparam int unsigned EXP_W_DEF = 8;
    localparam int unsigned MAN_W_DEF = 23;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RZ  = 2'b01;
    localparam logic [1:0] RM_RU  = 2'b10;
    localparam logic [1:0] RM_RD  = 2'b11;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_DENORM,
        CLS_NORM,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } cls_t;

    // Exponent+mantissa bits of the canonical quiet NaN (sign 0), right-aligned.
    function automatic logic [63:0] qnan_bits(input int unsigned exp_w, input int unsigned man_w);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < exp_w; i++) begin
            r[man_w + i] = 1'b1;
        end
        r[man_w - 1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational single-operand classifier (zero / denormal / normal / inf / qNaN / sNaN).
module fp_classify
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = EXP_W_DEF,
    parameter int unsigned MAN_W = MAN_W_DEF
) (
    input  logic [EXP_W-1:0] e,
    input  logic [MAN_W-1:0] m,
    output cls_t             cls
);

    always_comb begin
        cls = CLS_NORM;
        if (&e) begin
            if (m == '0)
                cls = CLS_INF;
            else
                cls = m[MAN_W-1] ? CLS_QNAN : CLS_SNAN;
        end else if (e == '0) begin
            cls = (m == '0) ? CLS_ZERO : CLS_DENORM;
        end
    end

endmodule

// File: rtl/fp_addsub_special_pipe.sv
// Special-operand result and flags for FP add/sub, delayed LATENCY cycles to match the adder.
// Optional flush-to-zero of denormal inputs: define FP_SPECIAL_FTZ_EN.
module fp_addsub_special_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W   = EXP_W_DEF,
    parameter int unsigned MAN_W   = MAN_W_DEF,
    parameter int unsigned LATENCY = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_valid,
    input  logic             Sx,
    input  logic [EXP_W-1:0] Ex,
    input  logic [MAN_W-1:0] Mx,
    input  logic             Sy,
    input  logic [EXP_W-1:0] Ey,
    input  logic [MAN_W-1:0] My,
    input  logic             sub,
    input  logic [1:0]       roundMode,
    output logic             out_valid,
    output logic             special,
    output logic             Sz,
    output logic [EXP_W-1:0] Ez,
    output logic [MAN_W-1:0] Mz,
    output logic             invalid_flag,
    output logic             zero_flag
);

    localparam logic [63:0] QNAN_FULL = qnan_bits(EXP_W, MAN_W);

    typedef struct packed {
        logic             valid;
        logic             special;
        logic             invalid;
        logic             zero;
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
    } stage_t;

    cls_t   cls_x, cls_y;
    stage_t next_stage;
    stage_t pipe_q [LATENCY];

    logic sy_eff, rd;
    logic x_nan, y_nan, x_snan, y_snan, x_inf, y_inf, x_zero, y_zero;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_x (.e(Ex), .m(Mx), .cls(cls_x));
    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_y (.e(Ey), .m(My), .cls(cls_y));

    always_comb begin
        next_stage = '0;
        sy_eff = Sy ^ sub;
        rd     = (roundMode == RM_RD);
        x_snan = (cls_x == CLS_SNAN);
        y_snan = (cls_y == CLS_SNAN);
        x_nan  = x_snan || (cls_x == CLS_QNAN);
        y_nan  = y_snan || (cls_y == CLS_QNAN);
        x_inf  = (cls_x == CLS_INF);
        y_inf  = (cls_y == CLS_INF);
`ifdef FP_SPECIAL_FTZ_EN
        x_zero = (cls_x == CLS_ZERO) || (cls_x == CLS_DENORM);
        y_zero = (cls_y == CLS_ZERO) || (cls_y == CLS_DENORM);
`else
        x_zero = (cls_x == CLS_ZERO);
        y_zero = (cls_y == CLS_ZERO);
`endif
        next_stage.special = 1'b1;
        if (x_nan || y_nan) begin
            {next_stage.e, next_stage.m} = QNAN_FULL[EXP_W+MAN_W-1:0];
            next_stage.invalid = x_snan | y_snan;
        end else if (x_inf && y_inf && (Sx != sy_eff)) begin
            {next_stage.e, next_stage.m} = QNAN_FULL[EXP_W+MAN_W-1:0];
            next_stage.invalid = 1'b1;
        end else if (x_inf) begin
            {next_stage.s, next_stage.e, next_stage.m} = {Sx, Ex, Mx};
        end else if (y_inf) begin
            {next_stage.s, next_stage.e, next_stage.m} = {sy_eff, Ey, My};
        end else if (x_zero && y_zero) begin
            next_stage.s    = rd ? (Sx | sy_eff) : (Sx & sy_eff);
            next_stage.zero = 1'b1;
        end else if (x_zero) begin
            {next_stage.s, next_stage.e, next_stage.m} = {sy_eff, Ey, My};
`ifdef FP_SPECIAL_FTZ_EN
            if (cls_y == CLS_DENORM) next_stage.m = '0;
`endif
        end else if (y_zero) begin
            {next_stage.s, next_stage.e, next_stage.m} = {Sx, Ex, Mx};
`ifdef FP_SPECIAL_FTZ_EN
            if (cls_x == CLS_DENORM) next_stage.m = '0;
`endif
        end else if ((Ex == Ey) && (Mx == My) && (Sx != sy_eff)) begin
            next_stage.s    = rd;
            next_stage.zero = 1'b1;
        end else begin
            next_stage.special = 1'b0;
        end
        next_stage.valid = 1'b1;
        if (!in_valid) next_stage = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else if (enable) begin
            pipe_q[0] <= next_stage;
            for (int unsigned i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign out_valid    = pipe_q[LATENCY-1].valid;
    assign special      = pipe_q[LATENCY-1].special;
    assign invalid_flag = pipe_q[LATENCY-1].invalid;
    assign zero_flag    = pipe_q[LATENCY-1].zero;
    assign Sz           = pipe_q[LATENCY-1].s;
    assign Ez           = pipe_q[LATENCY-1].e;
    assign Mz           = pipe_q[LATENCY-1].m;

endmodule
